// File: rtl/alu_accumulator_pkg.sv
// alu_accumulator_pkg: shared data width and alu_func function codes
package alu_accumulator_pkg;
  localparam int data_width = 16;
  typedef logic [3:0] func_t;
  localparam func_t FUNC_AND  = 4'h0;
  localparam func_t FUNC_OR   = 4'h1;
  localparam func_t FUNC_XOR  = 4'h2;
  localparam func_t FUNC_NOT  = 4'h3;
  localparam func_t FUNC_ADD  = 4'h4;
  localparam func_t FUNC_SUB  = 4'h5;
  localparam func_t FUNC_ID   = 4'h6;
  localparam func_t FUNC_ZERO = 4'h7;
endpackage

// File: rtl/alu_accumulator_if.sv
// alu_accumulator_if: operand-in and result-out valid/ready handshakes
interface alu_accumulator_if;
  import alu_accumulator_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [data_width-1:0] B;
  func_t FuncCode;
  logic out_valid;
  logic out_ready;
  logic [data_width-1:0] C;
  logic OverflowFlag;
  logic StickyOverflow;
  modport master (output in_valid, B, FuncCode, out_ready, input in_ready, out_valid, C, OverflowFlag, StickyOverflow);
  modport slave (input in_valid, B, FuncCode, out_ready, output in_ready, out_valid, C, OverflowFlag, StickyOverflow);
endinterface

// File: rtl/alu_accumulator_addsub_core.sv
// addsub_core: combinational two's-complement add/sub with signed overflow
module addsub_core import alu_accumulator_pkg::*; (
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic                  sub,
  output logic [data_width-1:0] y,
  output logic                  ovf
);
  localparam int msb = data_width - 1;
  always_comb begin
    y = sub ? a - b : a + b;
    ovf = (sub ? a[msb] != b[msb] : a[msb] == b[msb]) && (y[msb] != a[msb]);
  end
endmodule

// File: rtl/alu_accumulator.sv
// alu_accumulator: back-pressured accumulator stage applying add/sub/load/clear ops
module alu_accumulator import alu_accumulator_pkg::*; (
  input logic clk,
  input logic reset,
  alu_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state;
  logic [data_width-1:0] acc, b_q, sum, nxt_acc;
  func_t func_q;
  logic ovf, arith, ovf_q, sticky, nxt_sticky, in_ready_q, out_valid_q;
  assign arith = (func_q == FUNC_ADD) || (func_q == FUNC_SUB);
  addsub_core u_core (.a(acc), .b(b_q), .sub(func_q == FUNC_SUB), .y(sum), .ovf(ovf));
  always_comb begin
    nxt_acc = arith ? sum : func_q == FUNC_ID ? b_q : func_q == FUNC_ZERO ? '0 : acc;
    nxt_sticky = func_q == FUNC_ZERO ? 1'b0 : sticky | (arith & ovf);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      b_q <= '0;
      func_q <= FUNC_ZERO;
      ovf_q <= 1'b0;
      sticky <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          b_q <= bus.B;
          func_q <= bus.FuncCode;
          in_ready_q <= 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          acc <= nxt_acc;
          ovf_q <= arith & ovf;
          sticky <= nxt_sticky;
          out_valid_q <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.C = acc;
  assign bus.OverflowFlag = ovf_q;
  assign bus.StickyOverflow = sticky;
endmodule
